prior_decoder: RTL and testbench
================================

# prior_decoder

Inverse of the priority encoder: accepts a stream of bit indices (valid/ready, with a frame-end `last` flag), decodes each into a one-hot position and ORs it into an accumulator word. At frame end it presents the accumulated `DATA_WIDTH`-bit mask on a valid/ready output port. It sits downstream of the encoder path and rebuilds request/flag vectors from encoded indices.

## Interface
- `DATA_WIDTH`, 8: width of decoded mask.
- `INDEX_WIDTH`, `$clog2(DATA_WIDTH)+1`: index width; the extra MSB allows the out-of-range "null" code.
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `idx_in` in `INDEX_WIDTH`: index to decode.
- `idx_valid` in 1: `idx_in`/`idx_last` valid.
- `idx_last` in 1: final index of the frame.
- `idx_ready` out 1: block accepts a beat this cycle.
- `data_out` out `DATA_WIDTH`: decoded frame mask.
- `cnt_out` out `INDEX_WIDTH`: accepted beats in frame, including nulls; saturating.
- `dup_err` out 1: frame contained a repeated in-range index (see Configuration).
- `out_valid` out 1: `data_out`/`cnt_out`/`dup_err` valid.
- `out_ready` in 1: downstream accepts the frame.

## Operation
- Two states: `ACCUM` (reset state), `HOLD`.
- `ACCUM`: `idx_ready`=1. On `idx_valid`:
  - if `idx_in < DATA_WIDTH`, OR `1 << idx_in` into accumulator; else (null code, e.g. 8..15 for the defaults) no bit is set.
  - increment beat counter, saturating at `2**INDEX_WIDTH-1`.
  - if `idx_last`: register `acc | onehot` into `data_out`, counter+1 into `cnt_out`, dup flag into `dup_err`; clear accumulator, counter, dup flag; go to `HOLD`.
- `HOLD`: `idx_ready`=0; `out_valid`=1. When `out_ready`=1: go to `ACCUM`.
- `data_out`, `cnt_out`, `dup_err` are stable while `out_valid`=1 and hold their last value after the handshake.
- Frame of only nulls: `data_out`=0, `cnt_out`=beat count.
- Single-beat frame (`idx_last` on first beat) is legal.

## Timing
- Reset (`rst_n`=0 at a clock edge): state `ACCUM`, accumulator 0, counter 0, `data_out`=0, `cnt_out`=0, `dup_err`=0, `out_valid`=0. `idx_ready` is 0 while `rst_n`=0, 1 on the first cycle after release.
- Reset mid-frame or in `HOLD` discards all partial/pending data; no output is produced.
- Latency: `out_valid` rises the cycle after the `last` beat handshake.
- `out_valid` falls the cycle after `out_valid && out_ready`; `idx_ready` rises in that same cycle.
- Throughput: one frame per ≥ (beats + 1) cycles; no overlap of accumulation and output hold.
- `idx_ready` depends only on state (registered); no combinational path from `out_ready` to `idx_ready`.
- `idx_valid` while `idx_ready`=0 is ignored; the source must hold the beat.

## Configuration
- `PRIOR_DECODER_DUP_ERR_EN` defined: a sticky per-frame flag sets when an accepted in-range index already has its accumulator bit set (including the `last` beat); reported on `dup_err` with the frame. Null codes never set it.
- Not defined: no duplicate-detection logic; `dup_err` tied 0. Mask behaviour is identical either way (duplicates OR in harmlessly).

## Test plan
- Reset, then frame indices 0,3,7 (last on 7), `out_ready`=1 -> `data_out`=8'b1000_1001, `cnt_out`=3, `dup_err`=0, `out_valid` high exactly 1 cycle, one cycle after the last beat.
- Single beat idx 8 (null) with last -> `data_out`=0, `cnt_out`=1.
- Frame 2,5,2 with macro defined -> `data_out`=8'b0010_0100, `cnt_out`=3, `dup_err`=1; without macro -> `dup_err`=0, same mask.
- Frame 1 (last), `out_ready`=0 for 5 cycles with `idx_valid` held high on idx 4 -> `idx_ready`=0 and `data_out`=8'h02 stable throughout; after `out_ready`, the next frame starts with idx 4 accepted.
- 20 beats of idx 6, last on 20th -> `data_out`=8'h40, `cnt_out`=15 (saturated).
- `rst_n` low for one cycle after beats 0,1 of a frame, then frame idx 4 (last) -> `data_out`=8'h10, `cnt_out`=1; no output from the aborted frame.

Source files
------------

// File: rtl/prior_decoder.sv
// Rebuilds a DATA_WIDTH-bit mask from a framed stream of bit indices; out-of-range codes are nulls.
// Optional duplicate-index detection is enabled by defining PRIOR_DECODER_DUP_ERR_EN.
module prior_decoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] idx_in,
  input  logic                   idx_valid,
  input  logic                   idx_last,
  output logic                   idx_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [INDEX_WIDTH-1:0] cnt_out,
  output logic                   dup_err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [INDEX_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [INDEX_WIDTH:0]   DW_CMP  = (INDEX_WIDTH + 1)'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0]  ONE     = {{(DATA_WIDTH - 1){1'b0}}, 1'b1};

  logic [0:0]             state_q, state_d;
  logic                   rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [INDEX_WIDTH-1:0] cnt_out_q, cnt_out_d;

  logic                   beat;
  logic                   in_range;
  logic [DATA_WIDTH-1:0]  onehot;
  logic [INDEX_WIDTH-1:0] cnt_inc;
  logic                   dup_now;

  assign beat     = rdy_q && idx_valid;
  assign in_range = {1'b0, idx_in} < DW_CMP;
  assign onehot   = in_range ? (ONE << idx_in) : '0;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef PRIOR_DECODER_DUP_ERR_EN
  logic dup_q, dup_d;
  logic dup_out_q, dup_out_d;

  // A null code has an all-zero onehot, so it can never register as a hit.
  assign dup_now = dup_q || (|(acc_q & onehot));

  always_comb begin
    dup_d     = dup_q;
    dup_out_d = dup_out_q;
    if (beat) begin
      dup_d = idx_last ? 1'b0 : dup_now;
      if (idx_last) dup_out_d = dup_now;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dup_q     <= 1'b0;
      dup_out_q <= 1'b0;
    end else begin
      dup_q     <= dup_d;
      dup_out_q <= dup_out_d;
    end
  end

  assign dup_err = dup_out_q;
`else
  assign dup_now = 1'b0;
  assign dup_err = dup_now;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    cnt_out_d = cnt_out_q;
    case (state_q)
      ST_ACCUM: begin
        if (beat) begin
          if (idx_last) begin
            data_d    = acc_q | onehot;
            cnt_out_d = cnt_inc;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = ST_HOLD;
          end else begin
            acc_d = acc_q | onehot;
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        if (out_ready) state_d = ST_ACCUM;
      end
    endcase
  end

  // Ready is registered from the next state so out_ready never reaches idx_ready combinationally.
  assign rdy_d = (state_d == ST_ACCUM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      rdy_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  assign idx_ready = rdy_q;
  assign out_valid = (state_q == ST_HOLD);
  assign data_out  = data_q;
  assign cnt_out   = cnt_out_q;

endmodule

// File: tb/tb_prior_decoder.sv
// Randomized and directed bench for prior_decoder against a frame-level reference model.
module tb_prior_decoder;
  localparam int DW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] idx_in = '0;
  logic          idx_valid = 1'b0;
  logic          idx_last = 1'b0;
  logic          idx_ready;
  logic [DW-1:0] data_out;
  logic [IW-1:0] cnt_out;
  logic          dup_err;
  logic          out_valid;
  logic          out_ready = 1'b0;

  prior_decoder #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .idx_in(idx_in), .idx_valid(idx_valid),
    .idx_last(idx_last), .idx_ready(idx_ready), .data_out(data_out),
    .cnt_out(cnt_out), .dup_err(dup_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int frm[$];
  bit gaps = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame result from first principles: OR of in-range positions, beat count capped at 15.
  function automatic void model(output logic [DW-1:0] m, output int c, output bit d);
    bit seen [DW];
    m = '0;
    d = 1'b0;
    foreach (seen[k]) seen[k] = 1'b0;
    foreach (frm[i]) begin
      if (frm[i] < DW) begin
        if (seen[frm[i]]) d = 1'b1;
        seen[frm[i]] = 1'b1;
        m = m | (DW'(1) << frm[i]);
      end
    end
    c = (frm.size() > 15) ? 15 : frm.size();
`ifndef PRIOR_DECODER_DUP_ERR_EN
    d = 1'b0;
`endif
  endfunction

  // All tasks are entered and left just after a falling edge.
  task automatic send_beat(input int v, input bit last);
    bit acc = 1'b0;
    int t = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        idx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
    end
    while (!acc && t < 50) begin
      idx_valid = 1'b1;
      idx_in    = v[IW-1:0];
      idx_last  = last;
      acc       = idx_ready;
      chk("ov_during_accum", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    chk("beat_accept_timeout", {31'd0, acc}, 32'd1);
    idx_valid = 1'b0;
    idx_last  = 1'b0;
  endtask

  task automatic run_frame(input int wait_cyc, input int pre_idx);
    logic [DW-1:0] m;
    int c;
    bit d;
    model(m, c, d);
    foreach (frm[i]) send_beat(frm[i], i == frm.size() - 1);
    if (pre_idx >= 0) begin
      idx_valid = 1'b1;
      idx_in    = pre_idx[IW-1:0];
    end
    chk("ov_rise", {31'd0, out_valid}, 32'd1);
    chk("rdy_in_hold", {31'd0, idx_ready}, 32'd0);
    chk("data", {24'd0, data_out}, {24'd0, m});
    chk("cnt", {28'd0, cnt_out}, c);
    chk("dup", {31'd0, dup_err}, {31'd0, d});
    repeat (wait_cyc) begin
      @(posedge clk);
      @(negedge clk);
      chk("ov_hold", {31'd0, out_valid}, 32'd1);
      chk("rdy_hold", {31'd0, idx_ready}, 32'd0);
      chk("data_hold", {24'd0, data_out}, {24'd0, m});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("ov_fall", {31'd0, out_valid}, 32'd0);
    chk("rdy_rise", {31'd0, idx_ready}, 32'd1);
    chk("data_after", {24'd0, data_out}, {24'd0, m});
    chk("cnt_after", {28'd0, cnt_out}, c);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", {31'd0, idx_ready}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_cnt", {28'd0, cnt_out}, 32'd0);
    chk("rst_dup", {31'd0, dup_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_after_rst", {31'd0, idx_ready}, 32'd1);

    frm = '{0, 3, 7};
    run_frame(0, -1);
    chk("t1_mask", {24'd0, data_out}, 32'h89);

    frm = '{8};
    run_frame(0, -1);
    chk("t2_null", {24'd0, data_out}, 32'h00);

    frm = '{2, 5, 2};
    run_frame(1, -1);

    frm = '{1};
    run_frame(5, 4);
    frm = '{4};
    run_frame(0, -1);
    chk("t4_next", {24'd0, data_out}, 32'h10);

    frm.delete();
    repeat (20) frm.push_back(6);
    run_frame(0, -1);
    chk("t5_sat", {28'd0, cnt_out}, 32'd15);

    // Abort a partial frame with reset; nothing from it may appear.
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rdy", {31'd0, idx_ready}, 32'd0);
    chk("abort_ov", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ov2", {31'd0, out_valid}, 32'd0);
    frm = '{4};
    run_frame(0, -1);
    chk("t6_cnt", {28'd0, cnt_out}, 32'd1);

    gaps = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 20);
      frm.delete();
      for (int b = 0; b < len; b++) frm.push_back($urandom_range(0, 15));
      run_frame($urandom_range(0, 3), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
